// File: rtl/mod_chan_scheduler_if.sv
// mod_chan_scheduler_if
//
// Bundles the sequencer's traffic with the voice allocator and the shared
// modulation datapath into one connection.
//
//   master modport (the scheduler):
//      inputs  : sample_tick, chan_gate, mod_word_in
//      outputs : curr_note, note_enable, acc_en, word_valid, word_chan,
//                word_data, busy, sweep_done, overrun
//   slave modport (the surrounding system): the same signals, directions reversed.
interface mod_chan_scheduler_if #(
   parameter int NUM_CHAN = 16,
   parameter int NUM_BITS = 32
);
   localparam int IDX_W = $clog2(NUM_CHAN);

   logic                sample_tick;
   logic [NUM_CHAN-1:0] chan_gate;
   logic [NUM_BITS-1:0] mod_word_in;
   logic [NUM_CHAN-1:0] curr_note;
   logic [NUM_CHAN-1:0] note_enable;
   logic [NUM_CHAN-1:0] acc_en;
   logic                word_valid;
   logic [IDX_W-1:0]    word_chan;
   logic [NUM_BITS-1:0] word_data;
   logic                busy;
   logic                sweep_done;
   logic                overrun;

   modport master (
      input  sample_tick, chan_gate, mod_word_in,
      output curr_note, note_enable, acc_en, word_valid, word_chan,
             word_data, busy, sweep_done, overrun
   );

   modport slave (
      output sample_tick, chan_gate, mod_word_in,
      input  curr_note, note_enable, acc_en, word_valid, word_chan,
             word_data, busy, sweep_done, overrun
   );
endinterface

// File: rtl/mod_chan_scheduler.sv
// mod_chan_scheduler
//
// Time-multiplexing sequencer for the shared envelope/phase-modulation
// datapath. Each sample_tick starts one sweep over the channels: every channel
// gets a one-hot select held for SETTLE cycles, then a single commit cycle that
// pulses its accumulate enable and captures the modulated tuning word into an
// indexed output stream for the oscillator bank.
//
// Ports:
//   clk        - clock
//   rst        - synchronous, active-high reset; aborts a sweep immediately
//   bus        - mod_chan_scheduler_if.master:
//                sample_tick / chan_gate / mod_word_in in,
//                curr_note / note_enable / acc_en / word_valid / word_chan /
//                word_data / busy / sweep_done / overrun out
//
// Parameters: NUM_CHAN (>=2), NUM_BITS, SETTLE (0..15).
//
// Optional build macro MOD_SCHED_SKIP_IDLE_EN: channels whose gate snapshot is
// 0 are skipped with zero cycles, so released notes hold their envelope instead
// of decaying. Without it every channel is visited on every sweep.
module mod_chan_scheduler #(
   parameter int NUM_CHAN = 16,
   parameter int NUM_BITS = 32,
   parameter int SETTLE   = 1
) (
   input logic clk,
   input logic rst,
   mod_chan_scheduler_if.master bus
);
   localparam int IDX_W = $clog2(NUM_CHAN);

   typedef enum logic [1:0] {
      IDLE,
      HOLD,
      COMMIT
   } state_t;

   // With no settle time a channel goes straight from selection to commit.
   localparam state_t AFTER_SELECT = (SETTLE == 0) ? COMMIT : HOLD;
   localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHAN - 1);

   state_t              state_q, state_d;
   logic [IDX_W-1:0]    idx_q, idx_d;
   logic [3:0]          cnt_q, cnt_d;
   logic [NUM_CHAN-1:0] noteEnable_q, noteEnable_d;
   logic                wordValid_q, wordValid_d;
   logic [IDX_W-1:0]    wordChan_q, wordChan_d;
   logic [NUM_BITS-1:0] wordData_q, wordData_d;
   logic                sweepDone_q, sweepDone_d;
   logic                overrun_q, overrun_d;

   logic [NUM_CHAN-1:0] currNote;
   logic [NUM_CHAN-1:0] accEn;
   logic                busy;

   logic                startFound;
   logic [IDX_W-1:0]    startIdx;
   logic                lastChan;
   logic [IDX_W-1:0]    nextIdx;

`ifdef MOD_SCHED_SKIP_IDLE_EN
   // Priority search for the lowest active channel. At a tick the search runs
   // over the live gates because the snapshot is only being loaded that cycle;
   // mid-sweep it runs over the snapshot, strictly above the current index.
   // Iterating downwards lets the lowest qualifying channel win.
   always_comb begin
      startFound = 1'b0;
      startIdx   = '0;
      lastChan   = 1'b1;
      nextIdx    = '0;
      for (int i = NUM_CHAN - 1; i >= 0; i--) begin
         if (bus.chan_gate[i]) begin
            startFound = 1'b1;
            startIdx   = IDX_W'(i);
         end
         if (noteEnable_q[i] && (IDX_W'(i) > idx_q)) begin
            lastChan = 1'b0;
            nextIdx  = IDX_W'(i);
         end
      end
   end
`else
   // Every channel is visited in order, so the walk simply counts up.
   always_comb begin
      startFound = 1'b1;
      startIdx   = '0;
      lastChan   = (idx_q == LAST_IDX);
      nextIdx    = idx_q + IDX_W'(1);
   end
`endif

   // Next-state and output logic. Select and commit strobes are decoded from
   // the state here; the output stream and status pulses are computed as
   // next-state values so they appear registered one cycle after the commit.
   always_comb begin
      state_d      = state_q;
      idx_d        = idx_q;
      cnt_d        = cnt_q;
      noteEnable_d = noteEnable_q;
      wordValid_d  = 1'b0;
      wordChan_d   = wordChan_q;
      wordData_d   = wordData_q;
      sweepDone_d  = 1'b0;
      overrun_d    = 1'b0;
      currNote     = '0;
      accEn        = '0;
      busy         = 1'b0;

      case (state_q)
         IDLE: begin
            if (bus.sample_tick) begin
               noteEnable_d = bus.chan_gate;
               cnt_d        = '0;
               idx_d        = startIdx;
               if (startFound) begin
                  state_d = AFTER_SELECT;
               end else begin
                  sweepDone_d = 1'b1;
               end
            end
         end

         HOLD: begin
            busy      = 1'b1;
            currNote  = NUM_CHAN'(1) << idx_q;
            overrun_d = bus.sample_tick;
            if (cnt_q == SETTLE_LAST) begin
               cnt_d   = '0;
               state_d = COMMIT;
            end else begin
               cnt_d = cnt_q + 4'd1;
            end
         end

         COMMIT: begin
            busy        = 1'b1;
            currNote    = NUM_CHAN'(1) << idx_q;
            accEn       = NUM_CHAN'(1) << idx_q;
            overrun_d   = bus.sample_tick;
            wordValid_d = 1'b1;
            wordChan_d  = idx_q;
            wordData_d  = bus.mod_word_in;
            cnt_d       = '0;
            if (lastChan) begin
               idx_d       = '0;
               sweepDone_d = 1'b1;
               state_d     = IDLE;
            end else begin
               idx_d   = nextIdx;
               state_d = AFTER_SELECT;
            end
         end

         default: begin
            state_d = IDLE;
         end
      endcase

      // Reset is synchronous, but the datapath must not see a commit or a
      // select in the cycle the sweep is being torn down.
      if (rst) begin
         currNote = '0;
         accEn    = '0;
         busy     = 1'b0;
      end
   end

   // State and registered-output flops.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= IDLE;
         idx_q        <= '0;
         cnt_q        <= '0;
         noteEnable_q <= '0;
         wordValid_q  <= 1'b0;
         wordChan_q   <= '0;
         wordData_q   <= '0;
         sweepDone_q  <= 1'b0;
         overrun_q    <= 1'b0;
      end else begin
         state_q      <= state_d;
         idx_q        <= idx_d;
         cnt_q        <= cnt_d;
         noteEnable_q <= noteEnable_d;
         wordValid_q  <= wordValid_d;
         wordChan_q   <= wordChan_d;
         wordData_q   <= wordData_d;
         sweepDone_q  <= sweepDone_d;
         overrun_q    <= overrun_d;
      end
   end

   assign bus.curr_note   = currNote;
   assign bus.note_enable = noteEnable_q;
   assign bus.acc_en      = accEn;
   assign bus.word_valid  = wordValid_q;
   assign bus.word_chan   = wordChan_q;
   assign bus.word_data   = wordData_q;
   assign bus.busy        = busy;
   assign bus.sweep_done  = sweepDone_q;
   assign bus.overrun     = overrun_q;
endmodule

// File: tb/tb_mod_chan_scheduler.sv
// tb_mod_chan_scheduler
//
// Scoreboard bench for mod_chan_scheduler. Each tick pushes the commit
// strobes, output words, sweep_done and overrun events it should cause (with
// the cycle they should appear in) into queues; a free-running monitor pops
// and compares whenever the DUT presents one of those events.
module tb_mod_chan_scheduler;
   localparam int NUM_CHAN = 16;
   localparam int NUM_BITS = 32;
   localparam int SETTLE   = 1;
   localparam int PERIOD   = SETTLE + 1;
`ifdef MOD_SCHED_SKIP_IDLE_EN
   localparam bit SKIP_MODE = 1'b1;
`else
   localparam bit SKIP_MODE = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   vectors = 0;
   int   miscompares = 0;
   int   lastTick = 0;

   logic [NUM_BITS-1:0] wordBase  = '0;
   logic [NUM_CHAN-1:0] expNoteEn = '0;

   int                  accCycQ[$];
   logic [NUM_CHAN-1:0] accValQ[$];
   int                  wordCycQ[$];
   int                  wordChanQ[$];
   logic [NUM_BITS-1:0] wordDataQ[$];
   int                  doneQ[$];
   int                  ovQ[$];

   mod_chan_scheduler_if #(.NUM_CHAN(NUM_CHAN), .NUM_BITS(NUM_BITS)) bus ();

   mod_chan_scheduler #(
      .NUM_CHAN(NUM_CHAN),
      .NUM_BITS(NUM_BITS),
      .SETTLE  (SETTLE)
   ) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus.master)
   );

   // Free-running clock and a cycle counter that names each clock interval.
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Stand-in for the modulation datapath: the tuning word is a per-sweep base
   // plus the index of the currently selected channel.
   always_comb begin
      bus.mod_word_in = wordBase;
      for (int i = 0; i < NUM_CHAN; i++) begin
         if (bus.curr_note[i]) bus.mod_word_in = wordBase + NUM_BITS'(i);
      end
   end

   // Single comparison with a FAIL report on mismatch.
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("[TB] FAIL %s at cycle %0d: got %0h, required %0h", name, cyc, act, exp);
      end
   endtask

   task automatic flagUnexpected(input string name, input logic [63:0] act);
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s at cycle %0d: got %0h, required no event", name, cyc, act);
   endtask

   task automatic flagMissing(input string name, input int expCyc);
      vectors++;
      miscompares++;
      $display("[TB] FAIL %s: got no event, required one at cycle %0d", name, expCyc);
   endtask

   task automatic waitUntil(input int target);
      while (cyc < target) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Issue an accepted tick and enqueue everything the sweep should produce.
   // limit caps how many commits are expected (a sweep cut short by reset);
   // sweep_done is expected only if the whole sweep is allowed to finish.
   task automatic applyStimulus(input logic [NUM_CHAN-1:0] gate, input logic [NUM_BITS-1:0] base,
                                input int limit);
      int n;
      int t;
      int commitCyc;
      n = 0;
      t = cyc;
      lastTick = t;
      bus.sample_tick = 1'b1;
      bus.chan_gate   = gate;
      wordBase        = base;
      expNoteEn       = gate;
      for (int c = 0; c < NUM_CHAN; c++) begin
         if (!SKIP_MODE || gate[c]) begin
            if (n < limit) begin
               commitCyc = t + 1 + SETTLE + n * PERIOD;
               accCycQ.push_back(commitCyc);
               accValQ.push_back(NUM_CHAN'(1) << c);
               wordCycQ.push_back(commitCyc + 1);
               wordChanQ.push_back(c);
               wordDataQ.push_back(base + NUM_BITS'(c));
            end
            n++;
         end
      end
      if (n <= limit) doneQ.push_back(t + 1 + n * PERIOD);
      @(posedge clk);
      #1;
      bus.sample_tick = 1'b0;
   endtask

   // Tick issued while busy: must be dropped with a one-cycle overrun pulse.
   task automatic dropTick(input logic [NUM_CHAN-1:0] gate);
      bus.sample_tick = 1'b1;
      bus.chan_gate   = gate;
      ovQ.push_back(cyc + 1);
      @(posedge clk);
      #1;
      bus.sample_tick = 1'b0;
   endtask

   task automatic checkIdleOutputs(input string tag);
      checkOutput({tag, "_curr_note"},   64'(bus.curr_note),   64'd0);
      checkOutput({tag, "_note_enable"}, 64'(bus.note_enable), 64'd0);
      checkOutput({tag, "_acc_en"},      64'(bus.acc_en),      64'd0);
      checkOutput({tag, "_word_valid"},  64'(bus.word_valid),  64'd0);
      checkOutput({tag, "_word_chan"},   64'(bus.word_chan),   64'd0);
      checkOutput({tag, "_word_data"},   64'(bus.word_data),   64'd0);
      checkOutput({tag, "_busy"},        64'(bus.busy),        64'd0);
      checkOutput({tag, "_sweep_done"},  64'(bus.sweep_done),  64'd0);
      checkOutput({tag, "_overrun"},     64'(bus.overrun),     64'd0);
   endtask

   // Monitor: compares every event the DUT presents against the head of the
   // matching queue, and checks the select/snapshot while a sweep is running.
   always @(negedge clk) begin
      if (bus.acc_en != '0) begin
         if (accCycQ.size() == 0) flagUnexpected("acc_en", 64'(bus.acc_en));
         else begin
            checkOutput("acc_cycle", 64'(cyc), 64'(accCycQ.pop_front()));
            checkOutput("acc_value", 64'(bus.acc_en), 64'(accValQ.pop_front()));
         end
      end
      if (bus.word_valid) begin
         if (wordCycQ.size() == 0) flagUnexpected("word_valid", 64'(bus.word_chan));
         else begin
            checkOutput("word_cycle", 64'(cyc), 64'(wordCycQ.pop_front()));
            checkOutput("word_chan", 64'(bus.word_chan), 64'(wordChanQ.pop_front()));
            checkOutput("word_data", 64'(bus.word_data), 64'(wordDataQ.pop_front()));
         end
      end
      if (bus.sweep_done) begin
         if (doneQ.size() == 0) flagUnexpected("sweep_done", 64'(cyc));
         else checkOutput("done_cycle", 64'(cyc), 64'(doneQ.pop_front()));
      end
      if (bus.overrun) begin
         if (ovQ.size() == 0) flagUnexpected("overrun", 64'(cyc));
         else checkOutput("overrun_cycle", 64'(cyc), 64'(ovQ.pop_front()));
      end
      if (bus.busy) begin
         checkOutput("note_enable", 64'(bus.note_enable), 64'(expNoteEn));
         checkOutput("curr_onehot", 64'($onehot(bus.curr_note)), 64'd1);
      end
   end

   initial begin
      int t;
      bus.sample_tick = 1'b0;
      bus.chan_gate   = '0;

      // Reset state.
      repeat (3) @(posedge clk);
      @(negedge clk);
      checkIdleOutputs("reset");
      @(posedge clk);
      #1;
      rst = 1'b0;
      waitUntil(cyc + 2);

      // Full sweep, words 0x1000..0x100F.
      applyStimulus(16'hFFFF, 32'h0000_1000, NUM_CHAN);
      waitUntil(lastTick + 40);

      // Half the gates; a dropped tick carrying new gates mid-sweep.
      applyStimulus(16'h00FF, 32'h0000_2000, NUM_CHAN);
      t = lastTick;
      waitUntil(t + 10);
      dropTick(16'hFF00);
      waitUntil(t + 40);

      // Reset during channel 5's commit cycle.
      applyStimulus(16'hFFFF, 32'h0000_3000, 5);
      t = lastTick;
      waitUntil(t + 2 + 5 * PERIOD);
      rst = 1'b1;
      @(negedge clk);
      checkOutput("rst_cycle_acc_en", 64'(bus.acc_en), 64'd0);
      checkOutput("rst_cycle_curr_note", 64'(bus.curr_note), 64'd0);
      waitUntil(t + 3 + 5 * PERIOD);
      rst = 1'b0;
      @(negedge clk);
      checkIdleOutputs("post_rst");
      waitUntil(t + 45);

      // Back-to-back: a tick landing on the sweep_done cycle is accepted.
      applyStimulus(16'hFFFF, 32'h0000_4000, NUM_CHAN);
      waitUntil(lastTick + 1 + NUM_CHAN * PERIOD);
      applyStimulus(16'hFFFF, 32'h0000_5000, NUM_CHAN);
      waitUntil(lastTick + 40);

      // Sparse and empty gate patterns.
      applyStimulus(16'h8001, 32'h0000_6000, NUM_CHAN);
      waitUntil(lastTick + 40);
      applyStimulus(16'h0000, 32'h0000_7000, NUM_CHAN);
      waitUntil(lastTick + 40);

      // Anything still queued never appeared.
      while (accCycQ.size() > 0) flagMissing("acc_en", accCycQ.pop_front());
      while (wordCycQ.size() > 0) flagMissing("word_valid", wordCycQ.pop_front());
      while (doneQ.size() > 0) flagMissing("sweep_done", doneQ.pop_front());
      while (ovQ.size() > 0) flagMissing("overrun", ovQ.pop_front());

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end
endmodule

// File: doc/mod_chan_scheduler.md
# mod_chan_scheduler

Time-multiplexing sequencer for the shared envelope/phase-modulation datapath. On each audio sample tick it walks the channels in order. For each channel it presents a one-hot channel select, waits a fixed settle time, then pulses that channel's accumulate enable so the datapath commits the new envelope. The same cycle captures the modulated tuning word into an indexed output stream for the oscillator bank. It sits between the voice allocator (note gates) and the modulation datapath (`curr_note`, `note_enable`, `acc_en`, `modulated_tuning_word`).

## Interface
Parameters:
- `NUM_CHAN`, 16, number of time-multiplexed channels (≥2).
- `NUM_BITS`, 32, tuning word width.
- `SETTLE`, 1, cycles the select is held before commit (0–15).

Ports:
- `clk` in 1, clock.
- `rst` in 1, synchronous, active-high reset.
- `sample_tick` in 1, single-cycle pulse that starts one sweep.
- `chan_gate` in NUM_CHAN, note gates from the voice allocator.
- `mod_word_in` in NUM_BITS, modulated tuning word from the datapath.
- `curr_note` out NUM_CHAN, one-hot channel select to the datapath.
- `note_enable` out NUM_CHAN, gate snapshot to the datapath.
- `acc_en` out NUM_CHAN, one-hot commit pulse to the datapath.
- `word_valid` out 1, output stream valid.
- `word_chan` out $clog2(NUM_CHAN), channel index of `word_data`.
- `word_data` out NUM_BITS, captured tuning word.
- `busy` out 1, sweep in progress.
- `sweep_done` out 1, one-cycle pulse at the end of a sweep.
- `overrun` out 1, one-cycle pulse when a tick is dropped.

## Operation
- States:
  - IDLE
  - HOLD: select presented, settle counter running.
  - COMMIT: one cycle.
- IDLE:
  - `curr_note` = 0, `acc_en` = 0, `busy` = 0.
  - On `sample_tick`:
    - `note_enable` <= `chan_gate` (snapshot, constant for the whole sweep).
    - Channel index <= 0.
    - Go to HOLD, or directly to COMMIT if SETTLE = 0.
- HOLD:
  - `curr_note` = 1 << index.
  - Settle counter counts SETTLE cycles, then go to COMMIT.
- COMMIT:
  - `curr_note` still held.
  - `acc_en` = 1 << index.
  - `word_valid` = 1, `word_chan` = index, `word_data` = `mod_word_in` (all registered outputs, visible the following cycle).
  - If index = NUM_CHAN−1, go to IDLE. Otherwise increment the index and go to HOLD (or COMMIT if SETTLE = 0).
- `busy` = 1 in HOLD and COMMIT.
- `sweep_done` pulses in the first IDLE cycle after the last COMMIT.
- `sample_tick` while `busy`:
  - The tick is dropped and `overrun` pulses the next cycle.
  - The sweep continues unchanged.
- A tick coincident with the `sweep_done` cycle is accepted (the block is in IDLE).
- `chan_gate` changes mid-sweep have no effect until the next tick.
- `curr_note` and `acc_en` are never multi-hot. `acc_en` is non-zero only in COMMIT.

## Timing
- Reset: state IDLE, index 0, counter 0. All outputs 0, including `note_enable`, `word_*`, `busy`, `sweep_done`, `overrun`.
- Reset mid-sweep aborts the sweep immediately: no `acc_en` in the reset cycle and no `sweep_done`.
- The tick in cycle T gives HOLD for channel 0 in T+1.
- Per-channel period: SETTLE+1 cycles.
- Sweep length: NUM_CHAN·(SETTLE+1) cycles, with `sweep_done` at T+1+NUM_CHAN·(SETTLE+1).
- `word_valid` lags the corresponding `acc_en` by one cycle.
- Ticks must be spaced ≥ NUM_CHAN·(SETTLE+1)+1 cycles to avoid overrun.

## Configuration
- Macro: `MOD_SCHED_SKIP_IDLE_EN`.
- Undefined: every channel is visited each sweep, so released notes keep decaying.
- Defined:
  - Channels whose snapshot `note_enable` bit is 0 are skipped with zero cycles.
  - The next index comes from a priority search above the current index.
  - No `acc_en` and no `word_valid` occur for skipped channels, so their envelopes hold.
  - A sweep with no active channels goes from IDLE straight to `sweep_done` the cycle after the tick (`busy` stays 0).
  - Sweep length = (active count)·(SETTLE+1).

## Test plan
- Reset, then tick with SETTLE=1, NUM_CHAN=16 → `acc_en` walks 0x0001…0x8000 on every second cycle; `sweep_done` occurs 33 cycles after the tick; `word_chan` runs 0..15.
- `mod_word_in` = 0x1000+index during each HOLD → `word_data` sequence 0x1000..0x100F with matching `word_chan`.
- Second tick 10 cycles into a sweep → `overrun` pulse the next cycle; the sweep completes unchanged; exactly one `sweep_done`.
- `chan_gate` = 0x00FF at the tick, then 0xFF00 mid-sweep → `note_enable` = 0x00FF for the entire sweep.
- `rst` asserted during channel 5 COMMIT → no `acc_en` that cycle; all outputs 0 the next cycle; no `sweep_done`.
- With `MOD_SCHED_SKIP_IDLE_EN` and `chan_gate` = 0x8001 → only channels 0 and 15 commit; `sweep_done` occurs 5 cycles after the tick; with `chan_gate` = 0, `sweep_done` occurs 1 cycle after the tick.
